// File: rtl/temperature_monitor_seq_pkg.sv
// Shared types and helpers for the sequential temperature monitor.
// Holds the FSM state encoding, a constant clog2 and the default thresholds.
package temperature_monitor_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDivide,
        StFinish
    } state_e;

    localparam int unsigned DefNSensors = 5;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefTLow     = 19;
    localparam int unsigned DefTHigh    = 26;
    localparam int unsigned DefHyst     = 1;
    localparam int unsigned DefAlertCnt = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/temperature_monitor_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles after start.
// done_o flags the cycle whose closing edge writes the final quotient/remainder.
module temperature_monitor_seq_divider
    import temperature_monitor_seq_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    localparam int unsigned StepW = (clog2(W) > 0) ? clog2(W) : 1;

    logic [W-1:0]     quo_q, rem_q, div_q;
    logic [W-1:0]     quo_d, rem_d;
    logic [StepW-1:0] step_q;
    logic             busy_q;
    logic [W:0]       rem_sh;

    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        quo_d  = quo_q << 1;
        rem_d  = rem_sh[W-1:0];
        if (rem_sh >= {1'b0, div_q}) begin
            rem_d    = W'(rem_sh - {1'b0, div_q});
            quo_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            step_q <= step_q + StepW'(1);
            if (step_q == StepW'(W - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (step_q == StepW'(W - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/temperature_monitor_seq.sv
// Sequential sensor averager: accumulates enabled channels one per cycle, divides by the
// active count, rounds half-up and drives the LED value plus a debounced hysteresis alert.
module temperature_monitor_seq
    import temperature_monitor_seq_pkg::*;
#(
    parameter int unsigned N_SENSORS = DefNSensors,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned T_LOW     = DefTLow,
    parameter int unsigned T_HIGH    = DefTHigh,
    parameter int unsigned HYST      = DefHyst,
    parameter int unsigned ALERT_CNT = DefAlertCnt,
    localparam int unsigned CNT_W    = clog2(N_SENSORS + 1),
    localparam int unsigned SUM_W    = DATA_W + clog2(N_SENSORS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_SENSORS*DATA_W-1:0]   sensors_data_i,
    input  logic [N_SENSORS-1:0]          sensors_en_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    output logic [DATA_W-1:0]             led_output_o,
    output logic                          avg_valid_o,
    output logic [CNT_W-1:0]              nr_active_o,
    output logic                          no_sensor_o,
    output logic                          alert_o
);

    localparam int unsigned AcntW = clog2(ALERT_CNT + 1);

    state_e                        state_q;
    logic [N_SENSORS*DATA_W-1:0]   data_q;
    logic [N_SENSORS-1:0]          en_q;
    logic [CNT_W-1:0]              idx_q, cnt_q, cnt_d, nr_active_q;
    logic [SUM_W-1:0]              sum_q, sum_d;
    logic [DATA_W-1:0]             led_q, avg_sat;
    logic                          valid_q, no_sensor_q, alert_q;
    logic [AcntW-1:0]              set_cnt_q, clr_cnt_q, set_inc, clr_inc;
    logic                          last_chan, div_start, div_busy, div_done;
    logic [SUM_W-1:0]              div_q, div_r;
    logic [SUM_W:0]                rem2, avg_full;
    logic                          round_up, out_rng, in_rng;
    logic [31:0]                   avg_w;

    temperature_monitor_seq_divider #(
        .W (SUM_W)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (sum_d),
        .divisor_i   (SUM_W'(cnt_d)),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_q),
        .remainder_o (div_r)
    );

    always_comb begin
        // Data/enable registers shift down so channel k is always at the low slot.
        sum_d     = sum_q + (en_q[0] ? SUM_W'(data_q[DATA_W-1:0]) : SUM_W'(0));
        cnt_d     = cnt_q + CNT_W'(en_q[0]);
        last_chan = (idx_q == CNT_W'(N_SENSORS - 1));
        div_start = (state_q == StAccum) && last_chan && (cnt_d != '0) && !div_busy;

        rem2      = {div_r, 1'b0};
        round_up  = (rem2 >= (SUM_W + 1)'(cnt_q));
        avg_full  = {1'b0, div_q} + (SUM_W + 1)'(round_up);
        avg_sat   = (|avg_full[SUM_W:DATA_W]) ? '1 : avg_full[DATA_W-1:0];
        avg_w     = 32'(avg_sat);

        out_rng   = (avg_w < T_LOW) || (avg_w > T_HIGH);
        in_rng    = (avg_w >= T_LOW + HYST) && (avg_w <= T_HIGH - HYST);
        set_inc   = set_cnt_q + AcntW'(1);
        clr_inc   = clr_cnt_q + AcntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            data_q      <= '0;
            en_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            led_q       <= '0;
            valid_q     <= 1'b0;
            nr_active_q <= '0;
            no_sensor_q <= 1'b0;
            alert_q     <= 1'b0;
            set_cnt_q   <= '0;
            clr_cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (sample_valid_i) begin
                        data_q  <= sensors_data_i;
                        en_q    <= sensors_en_i;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    sum_q  <= sum_d;
                    cnt_q  <= cnt_d;
                    data_q <= data_q >> DATA_W;
                    en_q   <= en_q >> 1;
                    idx_q  <= idx_q + CNT_W'(1);
                    if (last_chan) begin
                        state_q <= (cnt_d == '0) ? StFinish : StDivide;
                    end
                end
                StDivide: begin
                    if (div_done) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    valid_q     <= 1'b1;
                    nr_active_q <= cnt_q;
                    state_q     <= StIdle;
                    if (cnt_q == '0) begin
                        led_q       <= '0;
                        no_sensor_q <= 1'b1;
                        alert_q     <= 1'b1;
                        set_cnt_q   <= '0;
                        clr_cnt_q   <= '0;
                    end else begin
                        led_q       <= avg_sat;
                        no_sensor_q <= 1'b0;
                        if (!alert_q) begin
                            clr_cnt_q <= '0;
                            if (!out_rng) begin
                                set_cnt_q <= '0;
                            end else if (set_inc == AcntW'(ALERT_CNT)) begin
                                alert_q   <= 1'b1;
                                set_cnt_q <= '0;
                            end else begin
                                set_cnt_q <= set_inc;
                            end
                        end else begin
                            set_cnt_q <= '0;
                            if (!in_rng) begin
                                clr_cnt_q <= '0;
                            end else if (clr_inc == AcntW'(ALERT_CNT)) begin
                                alert_q   <= 1'b0;
                                clr_cnt_q <= '0;
                            end else begin
                                clr_cnt_q <= clr_inc;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sample_ready_o = (state_q == StIdle);
    assign led_output_o   = led_q;
    assign avg_valid_o    = valid_q;
    assign nr_active_o    = nr_active_q;
    assign no_sensor_o    = no_sensor_q;
    assign alert_o        = alert_q;

endmodule

// File: tb/tb_temperature_monitor_seq.sv
// Self-checking bench for temperature_monitor_seq: directed scenarios plus random samples
// compared against an arithmetic reference model of average, rounding and alert debounce.
module tb_temperature_monitor_seq;

    localparam int N   = 5;
    localparam int DW  = 8;
    localparam int SW  = 11;
    localparam int TL  = 19;
    localparam int TH  = 26;
    localparam int HY  = 1;
    localparam int AC  = 2;
    localparam int LAT = N + SW + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] data = '0;
    logic [4:0]  en = '0;
    logic        valid = 1'b0;
    logic        ready, avg_valid, no_sensor, alert;
    logic [7:0]  led;
    logic [2:0]  nr;

    logic [95:0] wdata = '0;
    logic [7:0]  wen = '0;
    logic        wvalid = 1'b0;
    logic        wready, wavg_valid, wno, walert;
    logic [11:0] wled;
    logic [3:0]  wnr;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int m_alert = 0, m_set = 0, m_clr = 0;
    int exp_led, exp_nr, exp_ns, exp_lat, lat;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) n_acc <= n_acc + 1;
    end

    temperature_monitor_seq #(
        .N_SENSORS (N), .DATA_W (DW), .T_LOW (TL), .T_HIGH (TH), .HYST (HY), .ALERT_CNT (AC)
    ) dut (
        .clk_i (clk), .rst_i (rst), .sensors_data_i (data), .sensors_en_i (en),
        .sample_valid_i (valid), .sample_ready_o (ready), .led_output_o (led),
        .avg_valid_o (avg_valid), .nr_active_o (nr), .no_sensor_o (no_sensor), .alert_o (alert)
    );

    temperature_monitor_seq #(
        .N_SENSORS (8), .DATA_W (12), .T_LOW (TL), .T_HIGH (TH), .HYST (HY), .ALERT_CNT (AC)
    ) dut_w (
        .clk_i (clk), .rst_i (rst), .sensors_data_i (wdata), .sensors_en_i (wen),
        .sample_valid_i (wvalid), .sample_ready_o (wready), .led_output_o (wled),
        .avg_valid_o (wavg_valid), .nr_active_o (wnr), .no_sensor_o (wno), .alert_o (walert)
    );

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d,
                                       input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: rounded mean computed as floor((2*sum + cnt) / (2*cnt)).
    task automatic model_result(input logic [39:0] d, input logic [4:0] e);
        int s, c, avg;
        logic out_r, in_r;
        s = 0;
        c = 0;
        for (int k = 0; k < N; k++) begin
            if (e[k]) begin
                s += int'(d[k*8 +: 8]);
                c++;
            end
        end
        avg = (c == 0) ? 0 : (2 * s + c) / (2 * c);
        if (avg > 255) avg = 255;
        exp_led = avg;
        exp_nr  = c;
        exp_ns  = (c == 0) ? 1 : 0;
        exp_lat = (c == 0) ? N + 1 : LAT;
        out_r = (avg < TL) || (avg > TH);
        in_r  = (avg >= TL + HY) && (avg <= TH - HY);
        if (c == 0) begin
            m_alert = 1; m_set = 0; m_clr = 0;
        end else if (m_alert == 0) begin
            m_set = out_r ? m_set + 1 : 0;
            if (m_set >= AC) begin m_alert = 1; m_set = 0; end
        end else begin
            m_clr = in_r ? m_clr + 1 : 0;
            if (m_clr >= AC) begin m_alert = 0; m_clr = 0; end
        end
    endtask

    task automatic send(input logic [39:0] d, input logic [4:0] e);
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
        data = d; en = e; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        data = 40'({$urandom(), $urandom()});
        en = 5'($urandom());
        lat = 0;
        while (avg_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        model_result(d, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_alert = 0; m_set = 0; m_clr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ready, avg_valid, no_sensor, alert} !== 4'b1000) begin
            n_errors++; $display("FAIL reset_flags got %b want 1000", {ready, avg_valid, no_sensor, alert});
        end
        n_checks++;
        if (led !== 8'd0 || nr !== 3'd0) begin
            n_errors++; $display("FAIL reset_data got led=%0d nr=%0d want 0 0", led, nr);
        end
    endtask

    task automatic test_basic();
        send(pk(20, 22, 24, 26, 28), 5'h1f);
        n_checks++;
        if (lat !== LAT) begin n_errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        n_checks++;
        if (led !== 8'd24 || nr !== 3'd5 || alert !== 1'b0 || no_sensor !== 1'b0) begin
            n_errors++; $display("FAIL basic_result got led=%0d nr=%0d al=%b ns=%b want 24 5 0 0",
                                 led, nr, alert, no_sensor);
        end
        @(posedge clk); #1;
        n_checks++;
        if (avg_valid !== 1'b0 || led !== 8'd24 || ready !== 1'b1) begin
            n_errors++; $display("FAIL basic_pulse got v=%b led=%0d rdy=%b want 0 24 1",
                                 avg_valid, led, ready);
        end
    endtask

    task automatic test_rounding();
        send(pk(20, 21, 0, 0, 0), 5'b00011);
        n_checks++;
        if (led !== 8'd21 || nr !== 3'd2) begin
            n_errors++; $display("FAIL round_up got led=%0d nr=%0d want 21 2", led, nr);
        end
        send(pk(20, 20, 21, 99, 99), 5'b00111);
        n_checks++;
        if (led !== 8'd20 || nr !== 3'd3) begin
            n_errors++; $display("FAIL round_down got led=%0d nr=%0d want 20 3", led, nr);
        end
    endtask

    task automatic test_no_sensor();
        send(pk(200, 200, 200, 200, 200), 5'b00000);
        n_checks++;
        if (led !== 8'd0 || nr !== 3'd0 || no_sensor !== 1'b1 || alert !== 1'b1 || lat !== N + 1) begin
            n_errors++; $display("FAIL no_sensor got led=%0d nr=%0d ns=%b al=%b lat=%0d want 0 0 1 1 %0d",
                                 led, nr, no_sensor, alert, lat, N + 1);
        end
        send(pk(22, 22, 22, 22, 22), 5'h1f);
        n_checks++;
        if (alert !== 1'b1 || no_sensor !== 1'b0 || led !== 8'd22) begin
            n_errors++; $display("FAIL no_sensor_hold got al=%b ns=%b led=%0d want 1 0 22",
                                 alert, no_sensor, led);
        end
        send(pk(22, 22, 22, 22, 22), 5'h1f);
        n_checks++;
        if (alert !== 1'b0) begin n_errors++; $display("FAIL no_sensor_clear got %b want 0", alert); end
    endtask

    task automatic test_hysteresis();
        int vals[9]  = '{30, 22, 30, 30, 26, 26, 26, 25, 25};
        bit want[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            send(pk(vals[i], vals[i], vals[i], vals[i], vals[i]), 5'h1f);
            n_checks++;
            if (alert !== want[i] || led !== 8'(vals[i])) begin
                n_errors++; $display("FAIL hyst_%0d got al=%b led=%0d want %b %0d",
                                     i, alert, led, want[i], vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a0, g;
        a0 = n_acc;
        data = pk(20, 21, 22, 23, 24); en = 5'h1f; valid = 1'b1;
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1 data = pk(25, 25, 25, 25, 24);
        g = 0;
        while (avg_valid !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
        model_result(pk(20, 21, 22, 23, 24), 5'h1f);
        n_checks++;
        if (led !== 8'(exp_led) || avg_valid !== 1'b1) begin
            n_errors++; $display("FAIL b2b_first got led=%0d v=%b want %0d 1", led, avg_valid, exp_led);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        g = 0;
        while (avg_valid !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
        model_result(pk(25, 25, 25, 25, 24), 5'h1f);
        n_checks++;
        if (led !== 8'(exp_led) || g !== LAT) begin
            n_errors++; $display("FAIL b2b_second got led=%0d lat=%0d want %0d %0d", led, g, exp_led, LAT);
        end
        n_checks++;
        if (n_acc - a0 !== 2) begin n_errors++; $display("FAIL b2b_accepts got %0d want 2", n_acc - a0); end
    endtask

    task automatic test_random();
        logic [39:0] d;
        logic [4:0]  e;
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < N; k++) d[k*8 +: 8] = 8'($urandom_range(35, 10));
            e = 5'($urandom());
            send(d, e);
            n_checks++;
            if (led !== 8'(exp_led) || nr !== 3'(exp_nr) || no_sensor !== exp_ns[0] ||
                alert !== m_alert[0] || lat !== exp_lat) begin
                n_errors++;
                $display("FAIL rand_%0d got led=%0d nr=%0d ns=%b al=%b lat=%0d want %0d %0d %0d %0d %0d",
                         i, led, nr, no_sensor, alert, lat, exp_led, exp_nr, exp_ns, m_alert, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        send(pk(30, 30, 30, 30, 30), 5'h1f);
        data = pk(22, 22, 22, 22, 22); en = 5'h1f; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_alert = 0; m_set = 0; m_clr = 0;
        n_checks++;
        if ({ready, no_sensor, alert} !== 3'b100 || led !== 8'd0 || nr !== 3'd0) begin
            n_errors++; $display("FAIL midreset_state got rdy=%b ns=%b al=%b led=%0d nr=%0d want 1 0 0 0 0",
                                 ready, no_sensor, alert, led, nr);
        end
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (avg_valid === 1'b1) seen++; end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL midreset_pulse got %0d want 0", seen); end
        send(pk(30, 30, 30, 30, 30), 5'h1f);
        n_checks++;
        if (led !== 8'd30 || alert !== 1'b0) begin
            n_errors++; $display("FAIL midreset_after got led=%0d al=%b want 30 0", led, alert);
        end
    endtask

    task automatic test_wide();
        int g;
        wdata = '1; wen = 8'hff; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        wdata = '0;
        g = 0;
        while (wavg_valid !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
        n_checks++;
        if (wled !== 12'd4095 || wnr !== 4'd8 || wno !== 1'b0 || walert !== 1'b0 || g !== 8 + 15 + 1) begin
            n_errors++; $display("FAIL wide got led=%0d nr=%0d ns=%b al=%b lat=%0d want 4095 8 0 0 24",
                                 wled, wnr, wno, walert, g);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_no_sensor();
        test_hysteresis();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
